// File: rtl/mc_pkg.sv
// Shared constants, state encoding and decode bundle for the multi-cycle MIPS control unit.
// The optional MC_PERF_CNT_EN build enables the performance counters in mc_ctrl_fsm.
package mc_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;

   localparam logic [2:0] ALUOP_OR  = 3'b001;
   localparam logic [2:0] ALUOP_ADD = 3'b010;
   localparam logic [2:0] ALUOP_SUB = 3'b011;
   localparam logic [2:0] ALUOP_LUI = 3'b100;

   localparam logic [1:0] PCSRC_SEQ = 2'b00;
   localparam logic [1:0] PCSRC_BR  = 2'b01;
   localparam logic [1:0] PCSRC_JMP = 2'b10;
   localparam logic [1:0] PCSRC_REG = 2'b11;

   localparam logic [1:0] REGDST_RT = 2'b00;
   localparam logic [1:0] REGDST_RD = 2'b01;
   localparam logic [1:0] REGDST_RA = 2'b10;

   localparam logic [1:0] MEM2REG_ALU = 2'b00;
   localparam logic [1:0] MEM2REG_MEM = 2'b01;
   localparam logic [1:0] MEM2REG_PC4 = 2'b10;

   typedef enum logic [2:0] {
      ST_IF   = 3'd0,
      ST_ID   = 3'd1,
      ST_EX   = 3'd2,
      ST_MEM  = 3'd3,
      ST_WB   = 3'd4,
      ST_HALT = 3'd5
   } st_e;

   typedef struct packed {
      logic [1:0] reg_dst;
      logic       alu_src;
      logic [1:0] mem_to_reg;
      logic [1:0] pc_src;
      logic       ext_op;
      logic [2:0] alu_op;
      logic       is_jal;
      logic       is_jr;
      logic       is_br;
      logic       is_bne;
      logic       is_ld;
      logic       is_st;
      logic       illegal;
   } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Pure combinational opcode/function decoder: datapath selects,
// instruction-class flags and the illegal-instruction flag.
module mc_decode
   import mc_pkg::*;
(
   input  logic [5:0] i_op,
   input  logic [5:0] i_func,
   output dec_t       o_dec
);

   always_comb begin
      o_dec        = '0;
      o_dec.alu_op = ALUOP_ADD;
      unique case (i_op)
         OP_RTYPE: begin
            o_dec.reg_dst = REGDST_RD;
            unique case (i_func)
               FN_ADD:  o_dec.alu_op = ALUOP_ADD;
               FN_SUB:  o_dec.alu_op = ALUOP_SUB;
               FN_JR: begin
                  o_dec.is_jr  = 1'b1;
                  o_dec.pc_src = PCSRC_REG;
               end
               default: o_dec.illegal = 1'b1;
            endcase
         end
         OP_ORI: begin
            o_dec.alu_src = 1'b1;
            o_dec.ext_op  = 1'b1;
            o_dec.alu_op  = ALUOP_OR;
         end
         OP_LUI: begin
            o_dec.alu_src = 1'b1;
            o_dec.alu_op  = ALUOP_LUI;
         end
         OP_LW: begin
            o_dec.alu_src    = 1'b1;
            o_dec.mem_to_reg = MEM2REG_MEM;
            o_dec.is_ld      = 1'b1;
         end
         OP_SW: begin
            o_dec.alu_src = 1'b1;
            o_dec.is_st   = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            o_dec.alu_op = ALUOP_SUB;
            o_dec.pc_src = PCSRC_BR;
            o_dec.is_br  = 1'b1;
            o_dec.is_bne = (i_op == OP_BNE);
         end
         OP_JAL: begin
            o_dec.reg_dst    = REGDST_RA;
            o_dec.mem_to_reg = MEM2REG_PC4;
            o_dec.pc_src     = PCSRC_JMP;
            o_dec.is_jal     = 1'b1;
         end
         default: o_dec.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM with wait-state handshakes, bus timeout and illegal halt.
// Define MC_PERF_CNT_EN to build the cycle/retired-instruction counters.
module mc_ctrl_fsm
   import mc_pkg::*;
#(
   parameter int WAIT_MAX = 15,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [5:0]       op,
   input  logic [5:0]       func,
   input  logic             zero,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_req,
   output logic             dmem_req,
   output logic             ir_we,
   output logic             pc_we,
   output logic             reg_we,
   output logic             mem_we,
   output logic [1:0]       reg_dst,
   output logic             alu_src,
   output logic [1:0]       mem_to_reg,
   output logic [1:0]       pc_src,
   output logic             ext_op,
   output logic [2:0]       alu_op,
   output logic [2:0]       state,
   output logic             illegal,
   output logic             timeout,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt
);

   localparam int WW = $clog2(WAIT_MAX + 1);

   st_e           r_state;
   st_e           w_nxt;
   logic [WW-1:0] r_wait;
   logic          r_illegal;
   logic          r_timeout;
   dec_t          w_dec;
   logic          w_stall;
   logic          w_hit;
   logic          w_imem_req;
   logic          w_dmem_req;
   logic          w_ir_we;
   logic          w_pc_we;
   logic          w_reg_we;
   logic          w_mem_we;
   logic          w_set_ill;
   logic          w_set_to;

   mc_decode u_dec (
      .i_op   (op),
      .i_func (func),
      .o_dec  (w_dec)
   );

   assign w_stall = ((r_state == ST_IF) && !imem_ready) ||
                    ((r_state == ST_MEM) && !dmem_ready);
   // Ready in the threshold cycle clears w_stall, so it beats the timeout.
   assign w_hit   = w_stall && (r_wait == WW'(WAIT_MAX - 1));

   always_comb begin
      w_nxt      = r_state;
      w_imem_req = 1'b0;
      w_dmem_req = 1'b0;
      w_ir_we    = 1'b0;
      w_pc_we    = 1'b0;
      w_reg_we   = 1'b0;
      w_mem_we   = 1'b0;
      w_set_ill  = 1'b0;
      w_set_to   = 1'b0;
      unique case (r_state)
         ST_IF: begin
            w_imem_req = 1'b1;
            if (imem_ready) begin
               w_ir_we = 1'b1;
               w_pc_we = 1'b1;
               w_nxt   = ST_ID;
            end else if (w_hit) begin
               w_set_to = 1'b1;
               w_nxt    = ST_HALT;
            end
         end
         ST_ID: begin
            if (w_dec.illegal) begin
               w_set_ill = 1'b1;
               w_nxt     = ST_HALT;
            end else if (w_dec.is_jal) begin
               w_reg_we = 1'b1;
               w_pc_we  = 1'b1;
               w_nxt    = ST_IF;
            end else if (w_dec.is_jr) begin
               w_pc_we = 1'b1;
               w_nxt   = ST_IF;
            end else begin
               w_nxt = ST_EX;
            end
         end
         ST_EX: begin
            if (w_dec.is_ld || w_dec.is_st) begin
               w_nxt = ST_MEM;
            end else if (w_dec.is_br) begin
               w_pc_we = w_dec.is_bne ? !zero : zero;
               w_nxt   = ST_IF;
            end else begin
               w_nxt = ST_WB;
            end
         end
         ST_MEM: begin
            w_dmem_req = 1'b1;
            w_mem_we   = w_dec.is_st;
            if (dmem_ready) begin
               w_nxt = w_dec.is_st ? ST_IF : ST_WB;
            end else if (w_hit) begin
               w_set_to = 1'b1;
               w_nxt    = ST_HALT;
            end
         end
         ST_WB: begin
            w_reg_we = 1'b1;
            w_nxt    = ST_IF;
         end
         ST_HALT: w_nxt = ST_HALT;
         default: w_nxt = ST_HALT;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= ST_IF;
         r_wait    <= '0;
         r_illegal <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state <= w_nxt;
         r_wait  <= w_stall ? r_wait + WW'(1) : '0;
         if (w_set_ill) r_illegal <= 1'b1;
         if (w_set_to)  r_timeout <= 1'b1;
      end
   end

   // Strobes are gated by reset_n so nothing leaks while reset is held.
   assign imem_req   = reset_n && w_imem_req;
   assign dmem_req   = reset_n && w_dmem_req;
   assign ir_we      = reset_n && w_ir_we;
   assign pc_we      = reset_n && w_pc_we;
   assign reg_we     = reset_n && w_reg_we;
   assign mem_we     = reset_n && w_mem_we;

   assign reg_dst    = w_dec.reg_dst;
   assign alu_src    = w_dec.alu_src;
   assign mem_to_reg = w_dec.mem_to_reg;
   assign ext_op     = w_dec.ext_op;
   assign alu_op     = w_dec.alu_op;
   assign pc_src     = ((r_state == ST_ID) || (r_state == ST_EX)) ?
                       w_dec.pc_src : PCSRC_SEQ;
   assign state      = r_state;
   assign illegal    = r_illegal;
   assign timeout    = r_timeout;

`ifdef MC_PERF_CNT_EN
   logic [CNT_W-1:0] r_cyc;
   logic [CNT_W-1:0] r_ins;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cyc <= '0;
         r_ins <= '0;
      end else begin
         if (r_state != ST_HALT) r_cyc <= r_cyc + CNT_W'(1);
         if ((w_nxt == ST_IF) && (r_state != ST_IF) && (r_state != ST_HALT))
            r_ins <= r_ins + CNT_W'(1);
      end
   end

   assign cycle_cnt = r_cyc;
   assign instr_cnt = r_ins;
`else
   assign cycle_cnt = '0;
   assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: per-cycle expected rows queued by the driver,
// popped and compared by an independent monitor on the falling edge.
module tb_mc_ctrl_fsm;

   localparam logic [2:0] IF = 3'd0, ID = 3'd1, EX = 3'd2;
   localparam logic [2:0] MEM = 3'd3, WB = 3'd4, HALT = 3'd5;

   // {imem_req, dmem_req, ir_we, pc_we, reg_we, mem_we}
   localparam logic [5:0] S0   = 6'b000000;
   localparam logic [5:0] S_F  = 6'b101100;
   localparam logic [5:0] S_W  = 6'b100000;
   localparam logic [5:0] S_D  = 6'b010000;
   localparam logic [5:0] S_DS = 6'b010001;
   localparam logic [5:0] S_RW = 6'b000010;
   localparam logic [5:0] S_PC = 6'b000100;
   localparam logic [5:0] S_JL = 6'b000110;

   // {reg_dst, alu_src, mem_to_reg, pc_src, ext_op, alu_op}
   localparam logic [10:0] SEL_ADD = 11'b01_0_00_00_0_010;
   localparam logic [10:0] SEL_SUB = 11'b01_0_00_00_0_011;
   localparam logic [10:0] SEL_ORI = 11'b00_1_00_00_1_001;
   localparam logic [10:0] SEL_LUI = 11'b00_1_00_00_0_100;
   localparam logic [10:0] SEL_LW  = 11'b00_1_01_00_0_010;
   localparam logic [10:0] SEL_SW  = 11'b00_1_00_00_0_010;
   localparam logic [10:0] SEL_BR  = 11'b00_0_00_01_0_011;
   localparam logic [10:0] SEL_JAL = 11'b10_0_10_10_0_010;
   localparam logic [10:0] SEL_JR  = 11'b01_0_00_11_0_010;

`ifdef MC_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [5:0]  op = '0;
   logic [5:0]  func = '0;
   logic        zero = 1'b0;
   logic        imem_ready = 1'b0;
   logic        dmem_ready = 1'b0;
   logic        imem_req, dmem_req, ir_we, pc_we, reg_we, mem_we;
   logic [1:0]  reg_dst, mem_to_reg, pc_src;
   logic        alu_src, ext_op, illegal, timeout;
   logic [2:0]  alu_op, state;
   logic [31:0] cycle_cnt, instr_cnt;

   always #5 clk = ~clk;

   mc_ctrl_fsm #(.WAIT_MAX(15), .CNT_W(32)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .op         (op),
      .func       (func),
      .zero       (zero),
      .imem_ready (imem_ready),
      .dmem_ready (dmem_ready),
      .imem_req   (imem_req),
      .dmem_req   (dmem_req),
      .ir_we      (ir_we),
      .pc_we      (pc_we),
      .reg_we     (reg_we),
      .mem_we     (mem_we),
      .reg_dst    (reg_dst),
      .alu_src    (alu_src),
      .mem_to_reg (mem_to_reg),
      .pc_src     (pc_src),
      .ext_op     (ext_op),
      .alu_op     (alu_op),
      .state      (state),
      .illegal    (illegal),
      .timeout    (timeout),
      .cycle_cnt  (cycle_cnt),
      .instr_cnt  (instr_cnt)
   );

   typedef struct {
      int          id;
      logic [2:0]  st;
      logic [5:0]  stb;
      logic        sc;
      logic [10:0] sel;
      logic [1:0]  fl;
      int          cc;
      int          ic;
   } row_t;

   row_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   rid = 0;
   int   e_cyc = 0;
   int   e_ins = 0;
   logic e_ill = 1'b0;
   logic e_to = 1'b0;
   logic [2:0] prv = IF;
   logic [5:0] n_op = '0;
   logic [5:0] n_fn = '0;

   task automatic step(input logic rn, input logic ir, input logic dr,
                       input logic z, input logic [2:0] st,
                       input logic [5:0] stb, input logic sc = 1'b0,
                       input logic [10:0] sel = '0);
      row_t r;
      @(posedge clk); #1;
      reset_n = rn; imem_ready = ir; dmem_ready = dr; zero = z;
      op = n_op; func = n_fn;
      if (!rn) begin
         e_cyc = 0; e_ins = 0; e_ill = 1'b0; e_to = 1'b0; prv = IF;
      end else if (st == IF && prv != IF && prv != HALT) begin
         e_ins++;
      end
      r.id = rid; r.st = st; r.stb = stb; r.sc = sc; r.sel = sel;
      r.fl = {e_ill, e_to}; r.cc = e_cyc; r.ic = e_ins;
      rid++;
      q.push_back(r);
      if (rn) begin
         if (st != HALT) e_cyc++;
         prv = st;
      end
   endtask

   task automatic run_alu(input logic [5:0] o, input logic [5:0] f,
                          input logic [10:0] sel);
      n_op = o; n_fn = f;
      step(1, 1, 0, 0, IF, S_F);
      step(1, 0, 0, 0, ID, S0);
      step(1, 0, 0, 0, EX, S0);
      step(1, 0, 0, 0, WB, S_RW, 1, sel);
   endtask

   task automatic run_br(input logic [5:0] o, input logic z,
                         input logic taken);
      n_op = o; n_fn = '0;
      step(1, 1, 0, 0, IF, S_F);
      step(1, 0, 0, 0, ID, S0);
      step(1, 0, 0, z, EX, taken ? S_PC : S0, 1, SEL_BR);
   endtask

   initial begin : monitor
      row_t r;
      logic [5:0]  g_stb;
      logic [10:0] g_sel;
      int ec, ei;
      bit ok;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            r = q.pop_front();
            g_stb = {imem_req, dmem_req, ir_we, pc_we, reg_we, mem_we};
            g_sel = {reg_dst, alu_src, mem_to_reg, pc_src, ext_op, alu_op};
            ec = PERF ? r.cc : 0;
            ei = PERF ? r.ic : 0;
            ok = (state == r.st) && (g_stb == r.stb) &&
                 ({illegal, timeout} == r.fl) &&
                 (!r.sc || g_sel == r.sel) &&
                 (cycle_cnt == 32'(ec)) && (instr_cnt == 32'(ei));
            n_chk++;
            if (!ok) begin
               n_fail++;
               $display("FAIL row%0d: got st=%0d stb=%b sel=%b fl=%b cc=%0d ic=%0d, exp st=%0d stb=%b sel=%b(chk %0b) fl=%b cc=%0d ic=%0d",
                        r.id, state, g_stb, g_sel, {illegal, timeout},
                        cycle_cnt, instr_cnt, r.st, r.stb, r.sel, r.sc,
                        r.fl, ec, ei);
            end
         end
      end
   end

   initial begin : driver
      step(0, 0, 0, 0, IF, S0);
      step(0, 1, 1, 0, IF, S0);

      run_alu(6'h00, 6'h20, SEL_ADD);

      n_op = 6'h23; n_fn = '0;
      step(1, 1, 0, 0, IF, S_F);
      step(1, 1, 0, 0, ID, S0);
      step(1, 1, 0, 0, EX, S0);
      step(1, 1, 0, 0, MEM, S_D, 1, SEL_LW);
      step(1, 1, 0, 0, MEM, S_D);
      step(1, 1, 0, 0, MEM, S_D);
      step(1, 0, 1, 0, MEM, S_D);
      step(1, 0, 0, 0, WB, S_RW, 1, SEL_LW);

      n_op = 6'h2B; n_fn = '0;
      step(1, 1, 0, 0, IF, S_F);
      step(1, 0, 1, 0, ID, S0);
      step(1, 0, 1, 0, EX, S0);
      step(1, 0, 1, 0, MEM, S_DS, 1, SEL_SW);

      run_br(6'h04, 1'b1, 1'b1);
      run_br(6'h04, 1'b0, 1'b0);
      run_br(6'h05, 1'b0, 1'b1);
      run_br(6'h05, 1'b1, 1'b0);

      n_op = 6'h03; n_fn = '0;
      step(1, 1, 0, 0, IF, S_F);
      step(1, 0, 0, 0, ID, S_JL, 1, SEL_JAL);

      n_op = 6'h00; n_fn = 6'h08;
      step(1, 1, 0, 0, IF, S_F);
      step(1, 0, 0, 0, ID, S_PC, 1, SEL_JR);

      run_alu(6'h0D, 6'h00, SEL_ORI);
      run_alu(6'h00, 6'h22, SEL_SUB);
      run_alu(6'h0F, 6'h00, SEL_LUI);

      // 14 wait cycles then ready: at the threshold, ready wins
      n_op = 6'h00; n_fn = 6'h20;
      for (int i = 0; i < 14; i++) step(1, 0, 0, 0, IF, S_W);
      step(1, 1, 0, 0, IF, S_F);
      step(1, 0, 0, 0, ID, S0);
      step(1, 0, 0, 0, EX, S0);
      step(1, 0, 0, 0, WB, S_RW, 1, SEL_ADD);

      for (int i = 0; i < 15; i++) step(1, 0, 0, 0, IF, S_W);
      e_to = 1'b1;
      step(1, 1, 1, 0, HALT, S0);
      step(1, 1, 1, 0, HALT, S0);
      step(1, 1, 1, 0, HALT, S0);
      step(0, 1, 1, 0, IF, S0);

      run_alu(6'h00, 6'h20, SEL_ADD);

      n_op = 6'h3F; n_fn = '0;
      step(1, 1, 0, 0, IF, S_F);
      step(1, 0, 0, 0, ID, S0);
      e_ill = 1'b1;
      step(1, 1, 1, 0, HALT, S0);
      step(1, 1, 1, 0, HALT, S0);

      n_op = 6'h00; n_fn = 6'h2A;
      step(0, 0, 0, 0, IF, S0);
      step(1, 1, 0, 0, IF, S_F);
      step(1, 0, 0, 0, ID, S0);
      e_ill = 1'b1;
      step(1, 0, 0, 0, HALT, S0);

      repeat (2) @(posedge clk);
      n_chk++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d rows left, expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
